// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Holds FSM encodings, hold-counter width and the rotating priority pick.
package shared_reg_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int CNT_W   = 4;
   localparam int MAX_REQ = 8;

   // First set request strictly after 'last', wrapping modulo n.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         last,
                                          input int                 n);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         if (i <= n) begin
            idx = (int'(last) + i) % n;
            if (!found && req[idx]) begin
               pick  = 3'(idx);
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/reg_cell.sv
// WIDTH-bit register with complementary outputs; qn resets to all ones.
// Latency: one clock from en/d to q/qn. No backpressure.
module reg_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q  <= '0;
         qn <= '1;
      end else if (en) begin
         q  <= d;
         qn <= ~d;
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one register among N_REQ level requesters.
// Latency: grant 1 cycle after req seen in IDLE, write+ack 1 cycle later;
// backpressure: requesters hold req until served, nothing is latched here.
module shared_reg_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         ack,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic [WIDTH-1:0]         q,
   output logic [WIDTH-1:0]         qn
);

   localparam int OW = $clog2(N_REQ);

   state_t           state;
   logic [OW-1:0]    last;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       pick;
   logic             wr_en;
   logic [WIDTH-1:0] wr_dat;

   always_comb begin
      pick   = rr_pick(8'(req), 3'(last), N_REQ);
      wr_en  = (state == ST_GRANT) && req[owner];
      wr_dat = wdata[owner*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         grant    <= '0;
         ack      <= '0;
         busy     <= 1'b0;
         owner    <= '0;
         last     <= OW'(N_REQ - 1);
         hold_cnt <= '0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  grant <= N_REQ'(1) << pick;
                  owner <= OW'(pick);
                  last  <= OW'(pick);
                  busy  <= 1'b1;
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // A dropped request aborts; the pointer keeps the aborted index.
               if (req[owner]) begin
                  ack <= grant;
                  if (HOLD_CYCLES == 0) begin
                     grant <= '0;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                     state    <= ST_HOLD;
                  end
               end else begin
                  grant <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (hold_cnt == '0) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   reg_cell #(.WIDTH(WIDTH)) u_shared_reg (
      .clk (clk),
      .rst (rst),
      .en  (wr_en),
      .d   (wr_dat),
      .q   (q),
      .qn  (qn)
   );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/acks, monitors pop and compare.
module tb_shared_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'hF;
   logic [31:0] wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
   logic [3:0]  grant, ack;
   logic [1:0]  owner;
   logic        busy;
   logic [7:0]  q, qn;

   logic        rst_b = 1'b1;
   logic [3:0]  req_b = 4'h0;
   logic [31:0] wdata_b = {8'h99, 8'h88, 8'h77, 8'h3C};
   logic [3:0]  grant_b, ack_b;
   logic [1:0]  owner_b;
   logic        busy_b;
   logic [7:0]  q_b, qn_b;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] owner;
      int         gap;
   } gexp_t;
   typedef struct packed {
      logic [3:0] ack;
      logic [7:0] q;
   } aexp_t;

   gexp_t gq[$];
   aexp_t aq[$];
   aexp_t bq[$];

   shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata), .grant(grant),
      .ack(ack), .owner(owner), .busy(busy), .q(q), .qn(qn)
   );

   shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut_h0 (
      .clk(clk), .rst(rst_b), .req(req_b), .wdata(wdata_b), .grant(grant_b),
      .ack(ack_b), .owner(owner_b), .busy(busy_b), .q(q_b), .qn(qn_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor for the HOLD_CYCLES=2 instance.
   logic [3:0] prev_grant = '0;
   int         last_gcyc  = 0;
   always @(negedge clk) begin
      gexp_t      g;
      aexp_t      a;
      logic [7:0] nq;
      if (grant != 0 && prev_grant == 0) begin
         if (gq.size() == 0) chk("unexpected_grant", 32'(grant), 0);
         else begin
            g = gq.pop_front();
            chk("grant", 32'(grant), 32'(g.grant));
            chk("owner", 32'(owner), 32'(g.owner));
            if (g.gap >= 0) chk("grant_gap", cyc - last_gcyc, g.gap);
         end
         last_gcyc = cyc;
      end
      if (ack != 0) begin
         nq = ~q;
         if (aq.size() == 0) chk("unexpected_ack", 32'(ack), 0);
         else begin
            a = aq.pop_front();
            chk("ack", 32'(ack), 32'(a.ack));
            chk("q", 32'(q), 32'(a.q));
            chk("qn", 32'(qn), 32'(nq));
            chk("ack_latency", cyc - last_gcyc, 1);
            chk("ack_in_grant", 32'(ack & grant), 32'(a.ack));
         end
      end
      if (!rst) chk("grant_onehot0", 32'($onehot0(grant)), 1);
      prev_grant = grant;
   end

   // Monitor for the HOLD_CYCLES=0 instance.
   logic [3:0] prev_grant_b = '0;
   int         last_acyc_b  = -1;
   always @(negedge clk) begin
      aexp_t      a;
      logic [7:0] nq;
      if (ack_b != 0) begin
         nq = ~q_b;
         if (bq.size() == 0) chk("h0_unexpected_ack", 32'(ack_b), 0);
         else begin
            a = bq.pop_front();
            chk("h0_ack", 32'(ack_b), 32'(a.ack));
            chk("h0_q", 32'(q_b), 32'(a.q));
            chk("h0_qn", 32'(qn_b), 32'(nq));
            chk("h0_grant_low", 32'(grant_b), 0);
            chk("h0_grant_prev", 32'(prev_grant_b), 32'(a.ack));
            if (last_acyc_b >= 0) chk("h0_ack_gap", cyc - last_acyc_b, 2);
         end
         last_acyc_b = cyc;
      end
      prev_grant_b = grant_b;
   end

   initial begin
      // Reset held two cycles with all requests asserted.
      tick(2);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_qn", 32'(qn), 32'hFF);
      rst = 1'b0;
      req = 4'h0;
      tick(2);

      // Single request from requester 2.
      req = 4'b0100;
      gq.push_back('{4'b0100, 2'd2, -1});
      aq.push_back('{4'b0100, 8'hA5});
      tick(2);
      req = 4'h0;
      tick(1);
      chk("single_busy_hold", 32'(busy), 1);
      tick(1);
      chk("single_busy_drop", 32'(busy), 0);
      tick(2);

      // Fairness from reset: 0,1,2,3,0 spaced 4 cycles.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      req = 4'hF;
      gq.push_back('{4'b0001, 2'd0, -1});
      gq.push_back('{4'b0010, 2'd1, 4});
      gq.push_back('{4'b0100, 2'd2, 4});
      gq.push_back('{4'b1000, 2'd3, 4});
      gq.push_back('{4'b0001, 2'd0, 4});
      aq.push_back('{4'b0001, 8'h11});
      aq.push_back('{4'b0010, 8'h22});
      aq.push_back('{4'b0100, 8'hA5});
      aq.push_back('{4'b1000, 8'h44});
      aq.push_back('{4'b0001, 8'h11});
      tick(18);
      req = 4'h0;
      tick(3);
      chk("fair_idle", 32'(busy), 0);

      // Abort: requester 1 drops during GRANT, requester 2 served next.
      req = 4'b0010;
      gq.push_back('{4'b0010, 2'd1, -1});
      tick(1);
      req = 4'b0100;
      gq.push_back('{4'b0100, 2'd2, 2});
      aq.push_back('{4'b0100, 8'hA5});
      tick(1);
      chk("abort_grant", 32'(grant), 0);
      chk("abort_ack", 32'(ack), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_q", 32'(q), 32'h11);
      tick(2);
      req = 4'h0;
      tick(3);

      // Reset in the middle of HOLD.
      req = 4'b1000;
      gq.push_back('{4'b1000, 2'd3, -1});
      aq.push_back('{4'b1000, 8'h44});
      tick(2);
      rst = 1'b1;
      req = 4'hF;
      tick(1);
      chk("midrst_grant", 32'(grant), 0);
      chk("midrst_ack", 32'(ack), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_owner", 32'(owner), 0);
      chk("midrst_q", 32'(q), 32'h00);
      chk("midrst_qn", 32'(qn), 32'hFF);
      rst = 1'b0;
      gq.push_back('{4'b0001, 2'd0, -1});
      aq.push_back('{4'b0001, 8'h11});
      tick(2);
      req = 4'h0;
      tick(4);

      // HOLD_CYCLES=0 instance: lone requester 0 re-granted every 2 cycles.
      rst_b = 1'b0;
      req_b = 4'b0001;
      repeat (4) bq.push_back('{4'b0001, 8'h3C});
      tick(8);
      req_b = 4'h0;
      tick(3);

      chk("sb_grant_drained", gq.size(), 0);
      chk("sb_ack_drained", aq.size(), 0);
      chk("sb_h0_drained", bq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
